data_restore: RTL and testbench

Receive-side OFDM (802.11a-style) data restore stage. It sits after the receive FFT and takes one frequency-domain sample per enable, tagged with an OFDM symbol number. It builds a per-subcarrier quadrant channel estimate from the two long training symbols and de-rotates each data subcarrier. It then hard-demaps QPSK and emits packed bytes on an AXI-Stream style output.

---
 rtl/data_restore.sv | 234 +++++++++++++++++++++++
 tb/tb_data_restore.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_restore.sv
// Receive-side OFDM data restore: LTS-based per-bin quadrant estimate, swap/negate
// de-rotation, QPSK hard demap and byte packing into a 32-deep FWFT output FIFO.
//   state   | meaning
//   IDLE    | quadrant table stable, waiting for entry into data symbols
//   CALC    | sweeping bins 0..63, writing quadrant of h[k]*L[k]
module data_restore (
  input  logic       CLK,
  input  logic       Rst_n,
  input  logic       io_inputDataEn,
  input  logic [7:0] io_inputDataR,
  input  logic [7:0] io_inputDataI,
  input  logic [7:0] io_inputSymbol,
  output logic       io_axisOut_valid,
  input  logic       io_axisOut_ready,
  output logic [7:0] io_axisOut_payload_data,
  output logic       io_axisOut_payload_last,
  output logic       io_axisOut_payload_user
);

  typedef enum logic {ST_IDLE, ST_CALC} calc_state_t;

  // {nonzero, negative} of the long training sequence, FFT bin order
  function automatic logic [1:0] lts_rom(input logic [5:0] k);
    logic [1:0] v;
    v = 2'b00;
    if ((k >= 6'd1 && k <= 6'd26) || k >= 6'd38) v = 2'b10;
    case (k)
      6'd2, 6'd3, 6'd6, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd17, 6'd18, 6'd20, 6'd22,
      6'd40, 6'd41, 6'd44, 6'd46, 6'd53, 6'd54, 6'd57, 6'd59: v = 2'b11;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic is_data_bin(input logic [5:0] k);
    return ((k >= 6'd1 && k <= 6'd26) || k >= 6'd38) &&
           k != 6'd7 && k != 6'd21 && k != 6'd43 && k != 6'd57;
  endfunction

  logic [7:0]        r_prev_sym;
  logic [6:0]        r_bin;
  logic signed [8:0] r_h_r [64];
  logic signed [8:0] r_h_i [64];
  logic [1:0]        r_q [64];
  logic              r_have_lts, r_q_valid;
  logic [5:0]        r_calc_idx;
  calc_state_t       r_state, w_state_nxt;

  logic              w_sym_chg, w_take, w_tag1, w_tag2, w_tag_data, w_calc_start;
  logic              w_calc_en, w_calc_last;
  logic [6:0]        w_bin;
  logic [5:0]        w_k;
  logic signed [8:0] w_in_r, w_in_i;

  assign w_sym_chg    = (io_inputSymbol != r_prev_sym);
  assign w_bin        = w_sym_chg ? 7'd0 : r_bin;
  assign w_k          = w_bin[5:0];
  assign w_take       = io_inputDataEn && !w_bin[6];
  assign w_tag1       = (io_inputSymbol == 8'd1);
  assign w_tag2       = (io_inputSymbol == 8'd2);
  assign w_tag_data   = (io_inputSymbol >= 8'd3);
  assign w_calc_start = (io_inputSymbol == 8'd3) && (r_prev_sym != 8'd3) && r_have_lts;
  assign w_in_r       = {io_inputDataR[7], io_inputDataR};
  assign w_in_i       = {io_inputDataI[7], io_inputDataI};

  always_ff @(posedge CLK) begin
    if (Rst_n) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_calc_en   = 1'b0;
    w_calc_last = 1'b0;
    case (r_state)
      ST_IDLE: if (w_calc_start) w_state_nxt = ST_CALC;
      ST_CALC: begin
        w_calc_en = 1'b1;
        if (r_calc_idx == 6'd63) begin
          w_calc_last = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic [1:0]        w_rom, w_qsel;
  logic signed [9:0] w_h_r10, w_h_i10, w_z_r, w_z_i, w_abs_r, w_abs_i;

  always_comb begin
    w_rom   = lts_rom(r_calc_idx);
    w_h_r10 = {r_h_r[r_calc_idx][8], r_h_r[r_calc_idx]};
    w_h_i10 = {r_h_i[r_calc_idx][8], r_h_i[r_calc_idx]};
    w_z_r   = w_rom[1] ? (w_rom[0] ? -w_h_r10 : w_h_r10) : 10'sd0;
    w_z_i   = w_rom[1] ? (w_rom[0] ? -w_h_i10 : w_h_i10) : 10'sd0;
    w_abs_r = w_z_r[9] ? -w_z_r : w_z_r;
    w_abs_i = w_z_i[9] ? -w_z_i : w_z_i;
    if (w_z_r >= w_abs_i)                   w_qsel = 2'd0;
    else if (w_z_i > w_abs_r)               w_qsel = 2'd1;
    else if (w_z_r[9] && w_abs_r >= w_abs_i) w_qsel = 2'd2;
    else                                    w_qsel = 2'd3;
  end

  always_ff @(posedge CLK) begin
    if (Rst_n) begin
      r_prev_sym <= '0;
      r_bin      <= '0;
      r_have_lts <= 1'b0;
      r_q_valid  <= 1'b0;
      r_calc_idx <= '0;
      for (int k = 0; k < 64; k++) begin
        r_h_r[k] <= '0;
        r_h_i[k] <= '0;
        r_q[k]   <= '0;
      end
    end else begin
      r_prev_sym <= io_inputSymbol;
      r_bin      <= w_bin + {6'd0, w_take};
      if (w_take && w_tag1) begin
        r_h_r[w_k] <= w_in_r;
        r_h_i[w_k] <= w_in_i;
        r_have_lts <= 1'b1;
        r_q_valid  <= 1'b0;
      end else if (w_take && w_tag2) begin
        r_h_r[w_k] <= r_h_r[w_k] + w_in_r;
        r_h_i[w_k] <= r_h_i[w_k] + w_in_i;
      end
      if (w_calc_en) begin
        r_q[r_calc_idx] <= w_qsel;
        r_calc_idx      <= r_calc_idx + 6'd1;
      end else begin
        r_calc_idx <= '0;
      end
      if (w_calc_last) r_q_valid <= 1'b1;
    end
  end

  // Stage 1 registers the carrier, stage 2 de-rotates/packs, stage 3 writes the FIFO
  logic              r_s1_vld;
  logic [7:0]        r_s1_r, r_s1_i;
  logic [1:0]        r_s1_q, r_car_cnt;
  logic [3:0]        r_byte_cnt;
  logic [5:0]        r_pack;
  logic              r_frame_pend, r_push;
  logic [9:0]        r_push_word;
  logic signed [8:0] w_s_r, w_s_i, w_dr, w_di;
  logic [1:0]        w_bits;

  assign w_s_r = {r_s1_r[7], r_s1_r};
  assign w_s_i = {r_s1_i[7], r_s1_i};

  always_comb begin
    case (r_s1_q)
      2'd0:    begin w_dr = w_s_r;  w_di = w_s_i;  end
      2'd1:    begin w_dr = w_s_i;  w_di = -w_s_r; end
      2'd2:    begin w_dr = -w_s_r; w_di = -w_s_i; end
      default: begin w_dr = -w_s_i; w_di = w_s_r;  end
    endcase
    w_bits = {!w_di[8], !w_dr[8]};
  end

  always_ff @(posedge CLK) begin
    if (Rst_n) begin
      r_s1_vld     <= 1'b0;
      r_s1_r       <= '0;
      r_s1_i       <= '0;
      r_s1_q       <= '0;
      r_car_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_pack       <= '0;
      r_frame_pend <= 1'b0;
      r_push       <= 1'b0;
      r_push_word  <= '0;
    end else begin
      r_s1_vld <= w_take && w_tag_data && r_q_valid && is_data_bin(w_k);
      r_s1_r   <= io_inputDataR;
      r_s1_i   <= io_inputDataI;
      r_s1_q   <= r_q[w_k];
      r_push   <= 1'b0;
      if (r_s1_vld) begin
        case (r_car_cnt)
          2'd0: r_pack[1:0] <= w_bits;
          2'd1: r_pack[3:2] <= w_bits;
          2'd2: r_pack[5:4] <= w_bits;
          default: begin
            r_push       <= 1'b1;
            r_push_word  <= {r_frame_pend, r_byte_cnt == 4'd11, w_bits, r_pack};
            r_frame_pend <= 1'b0;
            r_byte_cnt   <= (r_byte_cnt == 4'd11) ? 4'd0 : r_byte_cnt + 4'd1;
          end
        endcase
        r_car_cnt <= r_car_cnt + 2'd1;
      end
      if (w_take && w_tag1) begin
        r_car_cnt    <= '0;
        r_byte_cnt   <= '0;
        r_frame_pend <= 1'b1;
      end
    end
  end

  logic [9:0] r_mem [32];
  logic [4:0] r_wr, r_rd;
  logic [5:0] r_cnt;
  logic       w_push, w_pop;
  logic [9:0] w_head;

  assign w_push = r_push && (r_cnt != 6'd32);
  assign w_pop  = io_axisOut_valid && io_axisOut_ready;
  assign w_head = r_mem[r_rd];

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= r_push_word;
  end

  always_ff @(posedge CLK) begin
    if (Rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 5'd1;
      if (w_pop)  r_rd <= r_rd + 5'd1;
      r_cnt <= r_cnt + {5'd0, w_push} - {5'd0, w_pop};
    end
  end

  assign io_axisOut_valid        = (r_cnt != 6'd0);
  assign io_axisOut_payload_data = io_axisOut_valid ? w_head[7:0] : 8'h00;
  assign io_axisOut_payload_last = io_axisOut_valid && w_head[8];
  assign io_axisOut_payload_user = io_axisOut_valid && w_head[9];

endmodule

// File: tb/tb_data_restore.sv
// Scoreboard bench for data_restore: QPSK frames under channel rotation, stalls,
// overflow, extreme pilots/nulls and a mid-symbol reset.
module tb_data_restore;
  logic       CLK = 1'b0;
  logic       Rst_n;
  logic       io_inputDataEn;
  logic [7:0] io_inputDataR, io_inputDataI, io_inputSymbol;
  logic       io_axisOut_valid, io_axisOut_ready;
  logic [7:0] io_axisOut_payload_data;
  logic       io_axisOut_payload_last, io_axisOut_payload_user;

  data_restore dut (
    .CLK(CLK), .Rst_n(Rst_n),
    .io_inputDataEn(io_inputDataEn), .io_inputDataR(io_inputDataR),
    .io_inputDataI(io_inputDataI), .io_inputSymbol(io_inputSymbol),
    .io_axisOut_valid(io_axisOut_valid), .io_axisOut_ready(io_axisOut_ready),
    .io_axisOut_payload_data(io_axisOut_payload_data),
    .io_axisOut_payload_last(io_axisOut_payload_last),
    .io_axisOut_payload_user(io_axisOut_payload_user)
  );

  always #5 CLK = ~CLK;

  int         n_vec = 0, n_bad = 0, rx_cnt = 0, cyc = 0, lat_cyc = 0, rx0 = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obs_w, hold_w, want_w;
  logic       user_pend = 1'b0, suppress = 1'b0, lat_armed = 1'b0, hold_v = 1'b0;

  // 802.11a long training sequence, index -26..26
  int lts_l [53] = '{1,1,-1,-1,1,1,-1,1,-1,1,1,1,1,1,1,-1,-1,1,1,-1,1,-1,1,1,1,1, 0,
                     1,-1,-1,1,1,-1,1,-1,1,-1,-1,-1,-1,-1,1,1,-1,-1,1,-1,1,-1,1,1,1,1};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int lts_of(input int k);
    if (k <= 26) return lts_l[k + 26];
    if (k >= 38) return lts_l[k - 38];
    return 0;
  endfunction

  function automatic bit bench_is_data(input int k);
    if (k == 7 || k == 21 || k == 43 || k == 57) return 1'b0;
    return lts_of(k) != 0;
  endfunction

  function automatic void rot_sample(input int n, inout int r, inout int i);
    int t;
    for (int j = 0; j < n; j++) begin
      t = r;
      r = -i;
      i = t;
    end
  endfunction

  always @(negedge CLK) begin
    if (Rst_n == 1'b0) begin
      obs_w = {io_axisOut_payload_user, io_axisOut_payload_last, io_axisOut_payload_data};
      if (lat_armed && io_axisOut_valid) begin
        check_val("first_byte_latency", cyc - lat_cyc, 3);
        lat_armed = 1'b0;
      end
      if (io_axisOut_valid && !io_axisOut_ready) begin
        if (hold_v) check_val("stall_hold", obs_w, hold_w);
        hold_v = 1'b1;
        hold_w = obs_w;
      end else begin
        hold_v = 1'b0;
        if (io_axisOut_valid) begin
          rx_cnt++;
          if (exp_q.size() == 0) check_val("unexpected_byte_qsize", 0, 1);
          else begin
            want_w = exp_q.pop_front();
            check_val($sformatf("byte%0d", rx_cnt), obs_w, want_w);
          end
        end
      end
    end
  end

  task automatic drive(input logic en, input int tag, input int r, input int i);
    @(posedge CLK);
    #1;
    io_inputDataEn = en;
    io_inputSymbol = 8'(tag);
    io_inputDataR  = 8'(r);
    io_inputDataI  = 8'(i);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, int'(io_inputSymbol), 0, 0);
  endtask

  task automatic exp_push(input logic [7:0] b, input logic last, input bit arm);
    logic [9:0] w;
    if (suppress) return;
    w = {user_pend, last, b};
    user_pend = 1'b0;
    if (!io_axisOut_ready && exp_q.size() >= 32) return;
    exp_q.push_back(w);
    if (arm) begin
      lat_cyc   = cyc;
      lat_armed = 1'b1;
    end
  endtask

  task automatic send_lts(input int tag, input int rot);
    int r, i;
    for (int k = 0; k < 64; k++) begin
      r = 64 * lts_of(k);
      i = 0;
      rot_sample(rot, r, i);
      drive(1'b1, tag, r, i);
      drive(1'b0, tag, 0, 0);
    end
  endtask

  task automatic send_data(input int tag, input int rot, input bit extreme, input bit arm,
                           input int nbins);
    int         r, i, car, nb;
    logic [7:0] acc;
    logic       b0, b1;
    car = 0; nb = 0; acc = '0;
    for (int k = 0; k < nbins; k++) begin
      if (bench_is_data(k)) begin
        b0 = 1'($urandom_range(0, 1));
        b1 = 1'($urandom_range(0, 1));
        r = b0 ? 64 : -64;
        i = b1 ? 64 : -64;
        rot_sample(rot, r, i);
        drive(1'b1, tag, r, i);
        acc[2*car +: 2] = {b1, b0};
        car++;
        if (car == 4) begin
          exp_push(acc, nb == 11, arm && nb == 0);
          car = 0;
          nb++;
        end
      end else begin
        r = extreme ? ($urandom_range(0, 1) ? 127 : -127) : 0;
        i = extreme ? ($urandom_range(0, 1) ? 127 : -127) : 0;
        drive(1'b1, tag, r, i);
      end
    end
  endtask

  task automatic run_frame(input int rot, input int nsym, input bit extreme,
                           input int stall_first, input int stall_n, input bit arm);
    idle(4);
    drive(1'b0, 0, 0, 0);
    user_pend = 1'b1;
    send_lts(1, rot);
    send_lts(2, rot);
    drive(1'b0, 3, 0, 0);
    idle(130);
    for (int s = 0; s < nsym; s++) begin
      if (stall_n > 0 && s == stall_first) begin
        idle(8);
        io_axisOut_ready = 1'b0;
      end
      send_data(3 + s, rot, extreme, arm && s == 0, 64);
      if (stall_n > 0 && s == stall_first + stall_n - 1) begin
        idle(8);
        io_axisOut_ready = 1'b1;
      end
    end
    idle(60);
    check_val("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    Rst_n = 1'b1;
    io_inputDataEn = 1'b0;
    io_inputDataR = '0;
    io_inputDataI = '0;
    io_inputSymbol = '0;
    io_axisOut_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 Rst_n = 1'b0;
    @(negedge CLK);
    check_val("rst_valid", io_axisOut_valid, 0);
    check_val("rst_data", io_axisOut_payload_data, 0);
    check_val("rst_last", io_axisOut_payload_last, 0);
    check_val("rst_user", io_axisOut_payload_user, 0);

    rx0 = rx_cnt;
    run_frame(0, 20, 1'b0, -1, 0, 1'b1);
    check_val("ideal_frame_count", rx_cnt - rx0, 240);

    for (int rot = 1; rot < 4; rot++) begin
      rx0 = rx_cnt;
      run_frame(rot, 3, 1'b0, -1, 0, 1'b0);
      check_val($sformatf("rot%0d_count", rot), rx_cnt - rx0, 36);
    end

    rx0 = rx_cnt;
    run_frame(0, 3, 1'b0, 1, 2, 1'b0);
    check_val("backpressure_count", rx_cnt - rx0, 36);

    rx0 = rx_cnt;
    run_frame(1, 3, 1'b0, 0, 3, 1'b0);
    check_val("overflow_count", rx_cnt - rx0, 32);

    rx0 = rx_cnt;
    run_frame(2, 3, 1'b1, -1, 0, 1'b0);
    check_val("pilot_null_count", rx_cnt - rx0, 36);

    // mid-symbol reset with bytes waiting in the FIFO
    idle(4);
    drive(1'b0, 0, 0, 0);
    user_pend = 1'b1;
    send_lts(1, 0);
    send_lts(2, 0);
    drive(1'b0, 3, 0, 0);
    idle(130);
    send_data(3, 0, 1'b0, 1'b0, 64);
    idle(8);
    io_axisOut_ready = 1'b0;
    send_data(4, 0, 1'b0, 1'b0, 30);
    @(negedge CLK);
    check_val("valid_before_reset", io_axisOut_valid, 1);
    @(posedge CLK);
    #1;
    Rst_n = 1'b1;
    io_inputDataEn = 1'b0;
    exp_q.delete();
    hold_v = 1'b0;
    @(posedge CLK);
    #1 Rst_n = 1'b0;
    io_axisOut_ready = 1'b1;
    @(negedge CLK);
    check_val("valid_after_reset", io_axisOut_valid, 0);
    rx0 = rx_cnt;
    suppress = 1'b1;
    send_data(4, 0, 1'b0, 1'b0, 64);
    send_data(3, 0, 1'b0, 1'b0, 64);
    send_data(4, 0, 1'b0, 1'b0, 64);
    send_data(5, 0, 1'b0, 1'b0, 64);
    idle(20);
    suppress = 1'b0;
    check_val("no_output_after_reset", rx_cnt - rx0, 0);

    rx0 = rx_cnt;
    run_frame(0, 2, 1'b0, -1, 0, 1'b0);
    check_val("post_reset_frame_count", rx_cnt - rx0, 24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
